glb_ld_dma_sched: RTL

- Per-tile load-DMA queue scheduler in the global buffer tile.
- Consumes the QUEUE_DEPTH load-DMA header valid bits produced by the tile config registers.
- Sequences the load-DMA engine through the valid headers in order: issues a start per header, waits for completion, then pulses the matching per-entry invalidate back to the config block (hardware clear of the validate bit).
- Signals completion of the whole queue to the tile interrupt logic.

---
 rtl/glb_ld_dma_sched.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/glb_ld_dma_sched.sv
// glb_ld_dma_sched: walks the load-DMA header queue in order, starting the engine per valid header and clearing its validate bit on completion.
// Latency: start pulse -> dma_start two cycles later; dma_done -> next dma_start two cycles later; all outputs registered.
// Backpressure: none; one transfer is outstanding at a time. Optional watchdog built when GLB_LD_DMA_TIMEOUT_EN is defined.
module glb_ld_dma_sched #(
  parameter int QUEUE_DEPTH    = 4,
  parameter int QSEL_WIDTH     = $clog2(QUEUE_DEPTH),
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             cfg_ld_dma_mode,
  input  logic [QUEUE_DEPTH-1:0] hdr_valid,
  input  logic                   ld_dma_start_pulse,
  input  logic                   dma_done,
  output logic                   dma_start,
  output logic [QSEL_WIDTH-1:0]  dma_sel,
  output logic [QUEUE_DEPTH-1:0] cfg_load_dma_invalidate_pulse,
  output logic                   ld_dma_done_pulse,
  output logic                   busy,
  output logic                   err_timeout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    ISSUE = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [QSEL_WIDTH-1:0] PTR_LAST = QSEL_WIDTH'(QUEUE_DEPTH - 1);

  state_t                  state_q, state_d;
  logic [QSEL_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    mode_on;
  logic                    mode_rpt;
  logic                    run_end;

  logic                    start_d;
  logic                    done_d;
  logic                    busy_d;
  logic [QUEUE_DEPTH-1:0]  inval_d;

  // Modes 1 and 2 are active; 0 and 3 both mean off.
  assign mode_on  = (cfg_ld_dma_mode == 2'd1) || (cfg_ld_dma_mode == 2'd2);
  assign mode_rpt = (cfg_ld_dma_mode == 2'd2);

`ifdef GLB_LD_DMA_TIMEOUT_EN
  localparam logic [16:0] TMO_LAST = 17'(TIMEOUT_CYCLES - 1);

  logic [16:0] tmo_cnt_q;
  logic        tmo_expire;
  logic        err_timeout_q;

  // Counter holds k in the k-th cycle after RUN entry, so expiry ends RUN TIMEOUT_CYCLES cycles in.
  assign tmo_expire = (state_q == RUN) && (tmo_cnt_q == TMO_LAST);
  assign run_end    = dma_done || tmo_expire;
  assign err_timeout = err_timeout_q;

  // Watchdog: clear while issuing, count in RUN; a done in the expiry cycle is a normal completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q     <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      if (state_q == ISSUE) begin
        tmo_cnt_q <= '0;
      end else if (state_q == RUN) begin
        tmo_cnt_q <= tmo_cnt_q + 17'd1;
      end
      if (tmo_expire && !dma_done) begin
        err_timeout_q <= 1'b1;
      end
    end
  end
`else
  assign run_end     = dma_done;
  assign err_timeout = 1'b0;
`endif

  // State and queue pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state: scan stops at the first invalid entry (one-pass) or rewinds (repeat).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (ld_dma_start_pulse && mode_on) begin
          state_d = SCAN;
          ptr_d   = '0;
        end
      end
      SCAN: begin
        if (!mode_on) begin
          state_d = IDLE;
        end else if (hdr_valid[ptr_q]) begin
          state_d = ISSUE;
        end else if (mode_rpt) begin
          ptr_d = '0;
        end else begin
          state_d = DONE;
        end
      end
      ISSUE: begin
        state_d = RUN;
      end
      RUN: begin
        if (run_end) begin
          if (!mode_on) begin
            state_d = IDLE;
          end else if (ptr_q == PTR_LAST) begin
            if (mode_rpt) begin
              state_d = SCAN;
              ptr_d   = '0;
            end else begin
              state_d = DONE;
            end
          end else begin
            state_d = SCAN;
            ptr_d   = ptr_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state so every pulse leaves a flop aligned with its state.
  always_comb begin
    start_d = (state_d == ISSUE);
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
    inval_d = '0;
    // Repeat mode keeps its headers; any other mode at completion clears the finished entry.
    if ((state_q == RUN) && run_end && !mode_rpt) begin
      inval_d = QUEUE_DEPTH'(1) << ptr_q;
    end
  end

  // Registered outputs; reset wipes any pulse that would have fired next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      dma_start                     <= 1'b0;
      ld_dma_done_pulse             <= 1'b0;
      busy                          <= 1'b0;
      cfg_load_dma_invalidate_pulse <= '0;
    end else begin
      dma_start                     <= start_d;
      ld_dma_done_pulse             <= done_d;
      busy                          <= busy_d;
      cfg_load_dma_invalidate_pulse <= inval_d;
    end
  end

  assign dma_sel = ptr_q;

endmodule
